dmem_store_buffer: RTL
======================

DMEM_STORE_BUFFER -- requirements
Module: dmem_store_buffer

Interface
REQ-001 Parameter DEPTH, 4, entry count; power of two, minimum 2.
REQ-002 Parameter ADDR_W, 10, data-memory byte address width.
REQ-003 Parameter DATA_W, 32, store/load data width.
REQ-004 clock  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 st_valid  input  1  core store request (from the core's dmem write-enable).
REQ-007 st_addr  input  ADDR_W  store byte address (word aligned; bits [1:0] ignored).
REQ-008 st_data  input  DATA_W  store data.
REQ-009 st_ready  output  1  buffer accepts the store this cycle.
REQ-010 ld_addr  input  ADDR_W  core load address.
REQ-011 ld_data  output  DATA_W  load result, combinational.
REQ-012 mem_we  output  1  drain write strobe to data memory.
REQ-013 mem_addr  output  ADDR_W  drain write address.
REQ-014 mem_wd  output  DATA_W  drain write data.
REQ-015 mem_ready  input  1  memory accepts the drain write this cycle.
REQ-016 mem_raddr  output  ADDR_W  memory read address; always equals ld_addr.
REQ-017 mem_rd  input  DATA_W  memory read data (asynchronous read).
REQ-018 count  output  $clog2(DEPTH)+1  occupied entries.
REQ-019 empty  output  1  count == 0.

Function
REQ-020 Circular FIFO: head/tail pointers wrap modulo DEPTH; each entry holds addr[ADDR_W-1:2] and data.
REQ-021 st_ready SHALL be 1 when count < DEPTH, else 0; a same-cycle pop does not raise st_ready.
REQ-022 Push occurs on st_valid && st_ready; entry written at tail; tail advances.
REQ-023 mem_we SHALL equal !empty; mem_addr/mem_wd SHALL present the head entry.
REQ-024 Pop occurs on mem_we && mem_ready; head advances; head entry holds stable until popped.
REQ-025 Simultaneous push and pop: count unchanged; both pointers advance.
REQ-026 ld_data SHALL be the data of the youngest valid entry whose word address matches ld_addr[ADDR_W-1:2], else mem_rd.
REQ-027 Forwarding uses buffer state before the current edge; a same-cycle store is not forwarded.
REQ-028 Forwarding includes the head entry even if it pops on this edge.
REQ-029 Stores drain strictly in acceptance order; no reordering.
REQ-030 Latency: an accepted store reaches mem_we no earlier than the next cycle; with mem_ready held 1, exactly one cycle later.

Reset
REQ-031 On reset: head = tail = 0, count = 0, empty = 1, mem_we = 0, st_ready = 1; entry contents don't-care.
REQ-032 Reset mid-drain discards all pending entries; none is written after reset releases.

Configuration
REQ-033 Macro STORE_BUFFER_COALESCE_EN: when defined, a store whose word address matches the tail-most (youngest) entry SHALL overwrite that entry's data instead of pushing, provided that entry is not the head being popped this cycle.
REQ-034 With coalescing, st_ready SHALL be 1 for a coalescible store even when full.
REQ-035 Without the macro, every accepted store pushes a new entry.

Structure
REQ-036 Shared package global_types holds the store-entry struct typedef (word address, data) and the DEPTH default constant.
REQ-037 One sub-module, store_buffer_fwd, holds the youngest-match priority search (combinational), instantiated once.

Verification
REQ-038 Reset, store 0x1FC<=4 with mem_ready=1 -> next cycle mem_we=1, mem_addr=0x1FC, mem_wd=4; following cycle empty=1.
REQ-039 mem_ready=0, four stores 0x1FC/0x1F8/0x1F4/0x1F0 -> count=4, st_ready=0; fifth store stalls; then mem_ready=1 -> writes drain in order 0x1FC..0x1F0 over four cycles.
REQ-040 Pending 0x1F0<=0x3C, then 0x1F0<=0x2 (no coalesce build), ld_addr=0x1F0, mem_rd=0xDEAD -> ld_data=0x2 (youngest); ld_addr=0x100 -> ld_data=0xDEAD.
REQ-041 Full buffer with push and pop in the same cycle (mem_ready=1, st_ready=0) -> store stalls one cycle, accepted the next; count returns to 4.
REQ-042 Three entries pending, assert reset for one cycle -> mem_we=0, count=0; after release, mem_ready=1 for 5 cycles -> no memory write.
REQ-043 STORE_BUFFER_COALESCE_EN defined, mem_ready=0: stores 0x1E0<=1 then 0x1E0<=0x3C -> count=1, drained data 0x3C; undefined -> count=2, drains 1 then 0x3C.

Source files
------------

// File: rtl/dmem_store_buffer_pkg.sv
// rtl/dmem_store_buffer_pkg.sv - shared store-buffer types and defaults (package global_types)
package global_types;

  localparam int SB_DEPTH_DEFAULT = 4;
  localparam int SB_ADDR_W        = 10;
  localparam int SB_DATA_W        = 32;

  // One buffered store: word address (byte address without bits [1:0]) plus data.
  typedef struct packed {
    logic [SB_ADDR_W-3:0] waddr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_fwd.sv
// rtl/store_buffer_fwd.sv - youngest-match load forwarding search over buffered stores
module store_buffer_fwd
  import global_types::*;
#(
  parameter int DEPTH  = SB_DEPTH_DEFAULT,
  parameter int DATA_W = SB_DATA_W
) (
  input  sb_entry_t                 entries_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]  head_i,
  input  logic [$clog2(DEPTH):0]    count_i,
  input  logic [SB_ADDR_W-3:0]      waddr_i,
  input  logic [DATA_W-1:0]         mem_rd_i,
  output logic [DATA_W-1:0]         ld_data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so a later (younger) match overrides an older one.
  always_comb begin
    ld_data_o = mem_rd_i;
    idx       = head_i;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if (((PW+1)'(k) < count_i) && (entries_i[idx].waddr == waddr_i)) begin
        ld_data_o = DATA_W'(entries_i[idx].data);
      end
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - data-memory store buffer with load forwarding; STORE_BUFFER_COALESCE_EN enables youngest-entry coalescing
module dmem_store_buffer
  import global_types::*;
#(
  parameter int DEPTH  = SB_DEPTH_DEFAULT,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wd,
  input  logic                     mem_ready,
  output logic [ADDR_W-1:0]        mem_raddr,
  input  logic [DATA_W-1:0]        mem_rd,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = SB_ADDR_W - 2;

  sb_entry_t     entries_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic [EW-1:0] st_waddr, ld_waddr;
  logic          full, push, pop, coalesce;
  logic          unused_addr_lsbs;

  assign st_waddr         = EW'(st_addr[ADDR_W-1:2]);
  assign ld_waddr         = EW'(ld_addr[ADDR_W-1:2]);
  assign unused_addr_lsbs = ^st_addr[1:0];

  assign full   = (count_q == (PW+1)'(DEPTH));
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign mem_we = !empty;
  assign pop    = mem_we && mem_ready;

  assign mem_addr  = {(ADDR_W-2)'(entries_q[head_q].waddr), 2'b00};
  assign mem_wd    = DATA_W'(entries_q[head_q].data);
  assign mem_raddr = ld_addr;

`ifdef STORE_BUFFER_COALESCE_EN
  logic [PW-1:0] young_idx;
  assign young_idx = tail_q - PW'(1);
  // A lone entry that is draining this edge cannot absorb the store; it must push instead.
  assign coalesce  = st_valid && !empty && (entries_q[young_idx].waddr == st_waddr) &&
                     !(pop && (count_q == (PW+1)'(1)));
  assign st_ready  = !full || coalesce;
`else
  assign coalesce  = 1'b0;
  assign st_ready  = !full;
`endif

  assign push = st_valid && st_ready && !coalesce;

  always_comb begin
    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      entries_q[tail_q] <= '{waddr: st_waddr, data: SB_DATA_W'(st_data)};
    end
`ifdef STORE_BUFFER_COALESCE_EN
    else if (coalesce) begin
      entries_q[young_idx].data <= SB_DATA_W'(st_data);
    end
`endif
  end

  store_buffer_fwd #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fwd (
    .entries_i (entries_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .waddr_i   (ld_waddr),
    .mem_rd_i  (mem_rd),
    .ld_data_o (ld_data)
  );

endmodule
